// File: rtl/ts_bus_arbiter.sv
// ts_bus_arbiter: shares the TurboSound-FM PSG bus between the CPU port
// decoder (CPU) and the register-dump player (PLY).
// The block arbitrates round-robin. It skips the chip-select command when the
// cached config already matches the granted config. It then runs the SEL, ADR
// and DAT bus steps, each with SETUP, STROBE and RECOVER phases of PHASE
// clocks, so that the sound block's 2-flop input synchroniser can sample them.
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   TS_RESET              sound block reset elsewhere; drops the config cache
//   CPU_REQ/CFG/REG/DAT   CPU transaction request (level) and payload
//   CPU_ACK               one-clock completion pulse to CPU
//   PLY_REQ/CFG/REG/DAT   player transaction request (level) and payload
//   PLY_ACK               one-clock completion pulse to player
//   BDIR, BC, DO          PSG bus towards the sound block
//   BUSY                  high whenever the sequencer is not idle
module ts_bus_arbiter #(
  parameter int unsigned PHASE = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       TS_RESET,
  input  logic       CPU_REQ,
  input  logic [2:0] CPU_CFG,
  input  logic [7:0] CPU_REG,
  input  logic [7:0] CPU_DAT,
  output logic       CPU_ACK,
  input  logic       PLY_REQ,
  input  logic [2:0] PLY_CFG,
  input  logic [7:0] PLY_REG,
  input  logic [7:0] PLY_DAT,
  output logic       PLY_ACK,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  output logic       BUSY
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LD = CW'(PHASE - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [1:0] K_SEL = 2'd0;
  localparam logic [1:0] K_ADR = 2'd1;
  localparam logic [1:0] K_DAT = 2'd2;

  logic [1:0]    r_state, r_step;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_cfg, r_cache_cfg;
  logic [7:0]    r_reg, r_dat, r_do;
  logic          r_gnt_ply, r_last_ply, r_skip, r_cache_vld;
  logic          r_mask_cpu, r_mask_ply;
  logic          r_bdir, r_bc, r_busy, r_cpu_ack, r_ply_ack;

  logic [1:0]    w_nxt_state, w_nxt_step;
  logic [CW-1:0] w_nxt_cnt;
  logic [2:0]    w_nxt_cfg;
  logic [7:0]    w_nxt_reg, w_nxt_dat, w_nxt_do;
  logic          w_nxt_gply, w_nxt_last, w_nxt_skip;
  logic          w_nxt_bdir, w_nxt_bc, w_nxt_busy, w_nxt_ack;
  logic          w_cache_wr, w_last_cyc;
  logic          w_cpu_req, w_ply_req, w_gnt_cpu, w_gnt_ply;

  // A requester acknowledged last cycle may still hold REQ for one cycle.
  assign w_cpu_req  = CPU_REQ & ~r_mask_cpu;
  assign w_ply_req  = PLY_REQ & ~r_mask_ply;
  assign w_gnt_cpu  = w_cpu_req & (~w_ply_req | r_last_ply);
  assign w_gnt_ply  = w_ply_req & ~w_gnt_cpu;
  assign w_last_cyc = (r_cnt == '0);

  // Next-state logic: arbitration, phase counting and step sequencing.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_step  = r_step;
    w_nxt_cnt   = r_cnt;
    w_nxt_cfg   = r_cfg;
    w_nxt_reg   = r_reg;
    w_nxt_dat   = r_dat;
    w_nxt_gply  = r_gnt_ply;
    w_nxt_last  = r_last_ply;
    w_nxt_skip  = r_skip;
    w_cache_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_cpu | w_gnt_ply) begin
          w_nxt_gply = w_gnt_ply;
          w_nxt_last = w_gnt_ply;
          w_nxt_cfg  = w_gnt_ply ? PLY_CFG : CPU_CFG;
          w_nxt_reg  = w_gnt_ply ? PLY_REG : CPU_REG;
          w_nxt_dat  = w_gnt_ply ? PLY_DAT : CPU_DAT;
          if (w_nxt_reg[7:3] == 5'b11111) begin
            // Register aliases a select command: acknowledge from a single
            // quiet RECOVER cycle without touching the bus.
            w_nxt_state = S_RECOVER;
            w_nxt_step  = K_DAT;
            w_nxt_cnt   = '0;
            w_nxt_skip  = 1'b1;
          end else begin
            w_nxt_state = S_SETUP;
            w_nxt_cnt   = CNT_LD;
            w_nxt_skip  = 1'b0;
            w_nxt_step  = (!r_cache_vld || TS_RESET || (r_cache_cfg != w_nxt_cfg))
                          ? K_SEL : K_ADR;
          end
        end
      end
      S_SETUP: begin
        if (w_last_cyc) begin
          w_nxt_state = S_STROBE;
          w_nxt_cnt   = CNT_LD;
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (w_last_cyc) begin
          w_nxt_state = S_RECOVER;
          w_nxt_cnt   = CNT_LD;
          w_cache_wr  = (r_step == K_SEL);
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
        end
      end
      S_RECOVER: begin
        if (w_last_cyc) begin
          if (r_step == K_DAT) begin
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_SETUP;
            w_nxt_cnt   = CNT_LD;
            w_nxt_step  = (r_step == K_SEL) ? K_ADR : K_DAT;
          end
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Bus and handshake outputs for the coming cycle, registered below.
  always_comb begin
    w_nxt_bdir = (w_nxt_state == S_STROBE);
    w_nxt_busy = (w_nxt_state != S_IDLE);
    w_nxt_ack  = (w_nxt_state == S_RECOVER) && (w_nxt_step == K_DAT) &&
                 (w_nxt_cnt == '0);
    w_nxt_bc   = 1'b0;
    w_nxt_do   = 8'hFF;
    if ((w_nxt_state != S_IDLE) && !w_nxt_skip) begin
      case (w_nxt_step)
        K_SEL: begin
          w_nxt_bc = 1'b1;
          w_nxt_do = {5'b11111, w_nxt_cfg};
        end
        K_ADR: begin
          w_nxt_bc = 1'b1;
          w_nxt_do = w_nxt_reg;
        end
        default: begin
          w_nxt_bc = 1'b0;
          w_nxt_do = w_nxt_dat;
        end
      endcase
    end
  end

  // State, payload and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_step     <= K_SEL;
      r_cnt      <= '0;
      r_cfg      <= '0;
      r_reg      <= '0;
      r_dat      <= '0;
      r_gnt_ply  <= 1'b0;
      r_last_ply <= 1'b1;
      r_skip     <= 1'b0;
      r_bdir     <= 1'b0;
      r_bc       <= 1'b0;
      r_do       <= 8'hFF;
      r_busy     <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_ply_ack  <= 1'b0;
      r_mask_cpu <= 1'b0;
      r_mask_ply <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_step     <= w_nxt_step;
      r_cnt      <= w_nxt_cnt;
      r_cfg      <= w_nxt_cfg;
      r_reg      <= w_nxt_reg;
      r_dat      <= w_nxt_dat;
      r_gnt_ply  <= w_nxt_gply;
      r_last_ply <= w_nxt_last;
      r_skip     <= w_nxt_skip;
      r_bdir     <= w_nxt_bdir;
      r_bc       <= w_nxt_bc;
      r_do       <= w_nxt_do;
      r_busy     <= w_nxt_busy;
      r_cpu_ack  <= w_nxt_ack & ~w_nxt_gply;
      r_ply_ack  <= w_nxt_ack & w_nxt_gply;
      r_mask_cpu <= r_cpu_ack;
      r_mask_ply <= r_ply_ack;
    end
  end

  // Config cache; an external sound-block reset takes priority over a write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cache_vld <= 1'b0;
      r_cache_cfg <= '0;
    end else if (TS_RESET) begin
      r_cache_vld <= 1'b0;
    end else if (w_cache_wr) begin
      r_cache_vld <= 1'b1;
      r_cache_cfg <= r_cfg;
    end
  end

  assign BDIR    = r_bdir;
  assign BC      = r_bc;
  assign DO      = r_do;
  assign BUSY    = r_busy;
  assign CPU_ACK = r_cpu_ack;
  assign PLY_ACK = r_ply_ack;

endmodule

// File: tb/tb_ts_bus_arbiter.sv
// tb_ts_bus_arbiter: directed bench for ts_bus_arbiter with PHASE=4.
// Cycle k counts clocks after the grant cycle 0. Outputs are sampled on the
// falling edge.
module tb_ts_bus_arbiter;

  localparam int unsigned PHASE = 4;

  logic       CLK = 1'b0;
  logic       RESET_N, TS_RESET;
  logic       CPU_REQ, PLY_REQ, CPU_ACK, PLY_ACK;
  logic [2:0] CPU_CFG, PLY_CFG;
  logic [7:0] CPU_REG, CPU_DAT, PLY_REG, PLY_DAT, DO;
  logic       BDIR, BC, BUSY;

  int         n_err = 0;
  int         n_chk = 0;
  logic       hold_cpu = 1'b0;

  int         rise_cyc[$];
  logic [7:0] rise_do[$];
  logic       rise_bc[$];
  int         cpu_ack_cyc[$];
  int         ply_ack_cyc[$];
  int         busy_first, busy_last, busy_cnt;
  int         ack_seen;

  ts_bus_arbiter #(.PHASE(PHASE)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .TS_RESET(TS_RESET),
    .CPU_REQ(CPU_REQ), .CPU_CFG(CPU_CFG), .CPU_REG(CPU_REG), .CPU_DAT(CPU_DAT),
    .CPU_ACK(CPU_ACK),
    .PLY_REQ(PLY_REQ), .PLY_CFG(PLY_CFG), .PLY_REG(PLY_REG), .PLY_DAT(PLY_DAT),
    .PLY_ACK(PLY_ACK),
    .BDIR(BDIR), .BC(BC), .DO(DO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cpu_req(input logic [2:0] c, input logic [7:0] r, input logic [7:0] d);
    CPU_CFG = c; CPU_REG = r; CPU_DAT = d; CPU_REQ = 1'b1;
  endtask

  task automatic ply_req(input logic [2:0] c, input logic [7:0] r, input logic [7:0] d);
    PLY_CFG = c; PLY_REG = r; PLY_DAT = d; PLY_REQ = 1'b1;
  endtask

  // Records bus activity for cycles 1..ncyc. Requesters drop REQ on ACK.
  task automatic watch(input int ncyc);
    logic prev_bdir;
    prev_bdir = 1'b0;
    rise_cyc.delete(); rise_do.delete(); rise_bc.delete();
    cpu_ack_cyc.delete(); ply_ack_cyc.delete();
    busy_first = -1; busy_last = -1; busy_cnt = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge CLK);
      if (BDIR && !prev_bdir) begin
        if (rise_cyc.size() > 0)
          check("bdir_gap", 32'((k - rise_cyc[$]) >= int'(2 * PHASE)), 32'd1);
        rise_cyc.push_back(k); rise_do.push_back(DO); rise_bc.push_back(BC);
      end else if (BDIR && prev_bdir) begin
        check("do_hold", 32'(DO), 32'(rise_do[$]));
        check("bc_hold", 32'(BC), 32'(rise_bc[$]));
      end
      prev_bdir = BDIR;
      if (CPU_ACK) begin
        cpu_ack_cyc.push_back(k);
        if (!hold_cpu) CPU_REQ = 1'b0;
      end
      if (PLY_ACK) begin
        ply_ack_cyc.push_back(k);
        PLY_REQ = 1'b0;
      end
      if (BUSY) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
        busy_cnt++;
      end
    end
  endtask

  task automatic exp_rise(input string tag, input int idx, input int cyc,
                          input logic [7:0] d, input logic bc);
    if (idx < rise_cyc.size()) begin
      check({tag, "_cyc"}, 32'(rise_cyc[idx]), 32'(cyc));
      check({tag, "_do"},  32'(rise_do[idx]),  32'(d));
      check({tag, "_bc"},  32'(rise_bc[idx]),  32'(bc));
    end else begin
      check({tag, "_missing"}, 32'(rise_cyc.size()), 32'(idx + 1));
    end
  endtask

  task automatic exp_ack(input string tag, input int q[$], input int idx, input int cyc);
    if (idx < q.size()) check(tag, 32'(q[idx]), 32'(cyc));
    else                check({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
  endtask

  initial begin
    RESET_N = 1'b0; TS_RESET = 1'b0;
    CPU_REQ = 1'b0; CPU_CFG = '0; CPU_REG = '0; CPU_DAT = '0;
    PLY_REQ = 1'b0; PLY_CFG = '0; PLY_REG = '0; PLY_DAT = '0;
    repeat (3) @(negedge CLK);
    check("rst_bdir", 32'(BDIR), 32'd0);
    check("rst_bc",   32'(BC),   32'd0);
    check("rst_do",   32'(DO),   32'hFF);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_cack", 32'(CPU_ACK), 32'd0);
    check("rst_pack", 32'(PLY_ACK), 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // First transaction after reset issues select.
    cpu_req(3'b110, 8'h07, 8'h38);
    watch(40);
    check("t1_nrise", 32'(rise_cyc.size()), 32'd3);
    exp_rise("t1_sel", 0, 5,  8'hFE, 1'b1);
    exp_rise("t1_adr", 1, 17, 8'h07, 1'b1);
    exp_rise("t1_dat", 2, 29, 8'h38, 1'b0);
    check("t1_nack", 32'(cpu_ack_cyc.size()), 32'd1);
    exp_ack("t1_ack", cpu_ack_cyc, 0, 36);
    check("t1_pack", 32'(ply_ack_cyc.size()), 32'd0);
    check("t1_busy_first", 32'(busy_first), 32'd1);
    check("t1_busy_last",  32'(busy_last),  32'd36);
    check("t1_busy_cnt",   32'(busy_cnt),   32'd36);
    check("t1_idle_do", 32'(DO), 32'hFF);
    check("t1_idle_bc", 32'(BC), 32'd0);

    // Same config: the select step is skipped.
    cpu_req(3'b110, 8'h08, 8'h0F);
    watch(30);
    check("t2_nrise", 32'(rise_cyc.size()), 32'd2);
    exp_rise("t2_adr", 0, 5,  8'h08, 1'b1);
    exp_rise("t2_dat", 1, 17, 8'h0F, 1'b0);
    exp_ack("t2_ack", cpu_ack_cyc, 0, 24);

    // Simultaneous requests after reset: CPU first, then PLY with new config.
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    cpu_req(3'b110, 8'h01, 8'h11);
    ply_req(3'b111, 8'h02, 8'h22);
    watch(80);
    check("t3_nrise", 32'(rise_cyc.size()), 32'd6);
    exp_rise("t3_csel", 0, 5,  8'hFE, 1'b1);
    exp_rise("t3_cadr", 1, 17, 8'h01, 1'b1);
    exp_rise("t3_cdat", 2, 29, 8'h11, 1'b0);
    exp_rise("t3_psel", 3, 42, 8'hFF, 1'b1);
    exp_rise("t3_padr", 4, 54, 8'h02, 1'b1);
    exp_rise("t3_pdat", 5, 66, 8'h22, 1'b0);
    exp_ack("t3_cack", cpu_ack_cyc, 0, 36);
    exp_ack("t3_pack", ply_ack_cyc, 0, 73);

    // CPU holds REQ throughout: grants alternate CPU, PLY, CPU.
    repeat (2) @(negedge CLK);
    hold_cpu = 1'b1;
    cpu_req(3'b111, 8'h03, 8'h33);
    ply_req(3'b111, 8'h04, 8'h44);
    watch(75);
    hold_cpu = 1'b0;
    CPU_REQ = 1'b0;
    check("t4_nrise", 32'(rise_cyc.size()), 32'd6);
    exp_rise("t4_c1", 0, 5,  8'h03, 1'b1);
    exp_rise("t4_p",  2, 30, 8'h04, 1'b1);
    exp_rise("t4_c2", 4, 55, 8'h03, 1'b1);
    check("t4_ncack", 32'(cpu_ack_cyc.size()), 32'd2);
    exp_ack("t4_cack0", cpu_ack_cyc, 0, 24);
    exp_ack("t4_cack1", cpu_ack_cyc, 1, 74);
    exp_ack("t4_pack",  ply_ack_cyc, 0, 49);

    // Illegal register: quiet ACK one cycle after grant, cache kept.
    repeat (2) @(negedge CLK);
    cpu_req(3'b111, 8'hFA, 8'h55);
    watch(6);
    check("t5_nrise", 32'(rise_cyc.size()), 32'd0);
    exp_ack("t5_ack", cpu_ack_cyc, 0, 1);
    check("t5_busy_cnt", 32'(busy_cnt), 32'd1);
    check("t5_do", 32'(DO), 32'hFF);
    repeat (2) @(negedge CLK);
    cpu_req(3'b111, 8'h09, 8'h99);
    watch(30);
    check("t5b_nrise", 32'(rise_cyc.size()), 32'd2);
    exp_rise("t5b_adr", 0, 5, 8'h09, 1'b1);
    exp_ack("t5b_ack", cpu_ack_cyc, 0, 24);

    // TS_RESET between transactions forces a new select.
    TS_RESET = 1'b1;
    @(negedge CLK);
    TS_RESET = 1'b0;
    @(negedge CLK);
    cpu_req(3'b111, 8'h0A, 8'hAA);
    watch(40);
    check("t6_nrise", 32'(rise_cyc.size()), 32'd3);
    exp_rise("t6_sel", 0, 5, 8'hFF, 1'b1);
    exp_ack("t6_ack", cpu_ack_cyc, 0, 36);

    // RESET_N during ADR STROBE: bus idles at once, no ACK.
    repeat (2) @(negedge CLK);
    cpu_req(3'b111, 8'h0B, 8'hBB);
    repeat (6) @(negedge CLK);
    check("t7_strobe_bdir", 32'(BDIR), 32'd1);
    check("t7_strobe_do",   32'(DO),   32'h0B);
    RESET_N = 1'b0;
    #1;
    check("t7_rst_bdir", 32'(BDIR), 32'd0);
    check("t7_rst_do",   32'(DO),   32'hFF);
    check("t7_rst_bc",   32'(BC),   32'd0);
    check("t7_rst_busy", 32'(BUSY), 32'd0);
    CPU_REQ = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (CPU_ACK || PLY_ACK) ack_seen++;
    end
    check("t7_no_ack", 32'(ack_seen), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    cpu_req(3'b111, 8'h0B, 8'hBB);
    watch(40);
    check("t8_nrise", 32'(rise_cyc.size()), 32'd3);
    exp_rise("t8_sel", 0, 5,  8'hFF, 1'b1);
    exp_rise("t8_adr", 1, 17, 8'h0B, 1'b1);
    exp_rise("t8_dat", 2, 29, 8'hBB, 1'b0);
    exp_ack("t8_ack", cpu_ack_cyc, 0, 36);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ts_bus_arbiter.md
Name: ts_bus_arbiter

Overview:
- Shares the TurboSound-FM PSG bus (BDIR/BC/DI) between two requesters: the CPU port decoder (CPU) and the register-dump player (PLY).
- Each requester issues complete register-write transactions. A transaction carries a chip/config code, a register number and a data byte.
- The block arbitrates round-robin and re-issues the chip-select command (0xF8|CFG) only when the config code differs from the one last written.
- It then sequences address-latch and data-write bus cycles with hold times long enough for the sound block's 2-flop input synchroniser.

Parameters:
- PHASE, 4: clocks each bus phase (setup, strobe, recover) is held; legal range 3..15.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- TS_RESET  in  1  sound block was reset by another source; invalidates the config cache
- CPU_REQ  in  1  CPU transaction request; level, held until CPU_ACK
- CPU_CFG  in  3  CPU select code: bit0 chip, bit1 status select, bit2 FM disable
- CPU_REG  in  8  CPU target register number
- CPU_DAT  in  8  CPU write data
- CPU_ACK  out  1  one-clock completion pulse for CPU
- PLY_REQ  in  1  player transaction request; same rules as CPU_REQ
- PLY_CFG  in  3  player select code; same encoding as CPU_CFG
- PLY_REG  in  8  player target register number
- PLY_DAT  in  8  player write data
- PLY_ACK  out  1  one-clock completion pulse for player
- BDIR  out  1  to sound block BDIR
- BC  out  1  to sound block BC
- DO  out  8  to sound block DI
- BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset (RESET_N low, asynchronous): BDIR=0, BC=0, DO=0xFF, ACKs=0, BUSY=0, state=IDLE, cache invalid, last_grant=PLY (so CPU wins the first tie).
- Reset mid-transaction: bus returns to idle immediately and no ACK is issued. Requesters re-request after reset.
- Arbitration happens in IDLE only, once per cycle:
  - One requester high: that requester is granted.
  - Both high: the requester other than last_grant is granted.
  - last_grant updates at grant time.
  - The granted requester's CFG/REG/DAT are registered at grant; later input changes are ignored.
- ACK masking: in the single IDLE cycle after an ACK, the just-acknowledged requester's REQ is masked. Requesters must drop REQ within one cycle of ACK.
- Illegal register (REG[7:3]=11111, which would alias a select command): no bus activity. ACK is issued in the cycle after grant and the cache is unchanged.
- Steps, executed in order: SEL (only if cache invalid or cached CFG differs from granted CFG), ADR, DAT.
- Each step runs three phases, each exactly PHASE clocks:
  - SETUP: BDIR=0, BC and DO driven.
  - STROBE: BDIR=1, BC and DO held.
  - RECOVER: BDIR=0, BC and DO held.
- Step encodings:
  - SEL: BC=1, DO={5'b11111,CFG}.
  - ADR: BC=1, DO=REG.
  - DAT: BC=0, DO=DAT.
- After a step's RECOVER completes, DO returns to 0xFF and BC to 0 when entering IDLE.
- State encoding: IDLE, SETUP, STROBE, RECOVER plus a step register {SEL, ADR, DAT} and a phase counter (4 bits). The counter reloads at every phase change.
- Cache: written with the granted CFG at the end of SEL STROBE and marked valid.
- TS_RESET: cache goes invalid in the following cycle. If asserted during a transaction, the current transaction completes normally and the next transaction issues SEL.
- Latency, with grant in cycle 0:
  - First SETUP cycle is cycle 1.
  - Without SEL, ACK is asserted in cycle 6·PHASE (last DAT RECOVER cycle).
  - With SEL, ACK is in cycle 9·PHASE.
- ACK is exactly one clock, only to the granted requester. IDLE is re-entered in the cycle after ACK.
- BDIR rising edges are at least 2·PHASE clocks apart. DO/BC never change while BDIR=1.

Test Plan:
- Reset, then CPU_REQ with CFG=3'b110, REG=0x07, DAT=0x38 (PHASE=4) -> BDIR pulses at cycles 5, 17, 29 with DO 0xFE (BC=1), 0x07 (BC=1), 0x38 (BC=0); CPU_ACK at cycle 36; BUSY high cycles 1..36.
- Second CPU transaction, same CFG, REG=0x08, DAT=0x0F -> no select cycle; two BDIR pulses only; ACK 24 cycles after grant.
- CPU and PLY request in the same cycle after reset -> CPU granted first, PLY next. If PLY_CFG=3'b111 differs, PLY's transaction begins with DO=0xFF select cycle; PLY_ACK 36 cycles after its grant.
- CPU holds REQ continuously while PLY requests -> grants alternate CPU, PLY, CPU; no requester is served twice while the other waits.
- CPU_REG=0xFA -> no BDIR activity; CPU_ACK one cycle after grant; the next valid transaction with the same CFG issues no select if the cache was valid.
- TS_RESET pulse between transactions, then RESET_N low during ADR STROBE -> next transaction re-issues select; on reset, BDIR=0 and DO=0xFF immediately, no ACK, and the first post-reset transaction issues select.
